mult_result_checker: RTL

//  Downstream consumer of the combinational multiplier (A,B -> P) under design-space exploration.

---
 rtl/mult_result_checker.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/mult_result_checker.sv
// mult_result_checker
// Consumes {A,B,P} beats from the multiplier under exploration, recomputes the
// exact unsigned product and accumulates run statistics: pass/fail counts,
// saturating error-distance sum, maximum error and the first failing beat index.
// Beats flow through two register stages (capture, then compare), so a beat
// accepted at edge N appears in the statistics after edge N+2.

module mult_result_checker #(
    parameter int WIDTH       = 2,
    parameter int NUM_VECTORS = 20,
    parameter int CNT_W       = 16,
    parameter int ERR_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [2*WIDTH-1:0]   in_p,
    output logic                 done,
    output logic [CNT_W-1:0]     pass_cnt,
    output logic [CNT_W-1:0]     fail_cnt,
    output logic [ERR_W-1:0]     err_sum,
    output logic [2*WIDTH-1:0]   max_err,
    output logic [CNT_W-1:0]     first_fail_idx,
    output logic                 first_fail_vld
);

    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Control state
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   accepted_q, accepted_d;
    logic               done_q, done_d;

    // Stage 1: captured beat
    logic               s1_vld_q, s1_vld_d;
    logic [WIDTH-1:0]   s1_a_q, s1_a_d;
    logic [WIDTH-1:0]   s1_b_q, s1_b_d;
    logic [PW-1:0]      s1_p_q, s1_p_d;
    logic [CNT_W-1:0]   s1_idx_q, s1_idx_d;

    // Stage 2: compare result
    logic               s2_vld_q, s2_vld_d;
    logic               s2_fail_q, s2_fail_d;
    logic [PW-1:0]      s2_err_q, s2_err_d;
    logic [CNT_W-1:0]   s2_idx_q, s2_idx_d;

    // Statistics
    logic [CNT_W-1:0]   pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0]   fail_cnt_q, fail_cnt_d;
    logic [ERR_W-1:0]   err_sum_q, err_sum_d;
    logic [PW-1:0]      max_err_q, max_err_d;
    logic [CNT_W-1:0]   ffail_idx_q, ffail_idx_d;
    logic               ffail_vld_q, ffail_vld_d;

    // Combinational helpers
    logic               ready_w;
    logic               fire_w;
    logic [PW-1:0]      exp_w;
    logic [PW-1:0]      err_w;
    logic [ERR_W:0]     sum_ext_w;

    assign ready_w  = (state_q == ST_RUN) && (accepted_q < CNT_W'(NUM_VECTORS));
    assign fire_w   = in_valid && ready_w;
    assign exp_w    = PW'(s1_a_q) * PW'(s1_b_q);
    assign err_w    = (s1_p_q >= exp_w) ? (s1_p_q - exp_w) : (exp_w - s1_p_q);
    assign sum_ext_w = {1'b0, err_sum_q} + {{(ERR_W + 1 - PW){1'b0}}, s2_err_q};

    // Next-state logic: pipeline advance, statistics update, then FSM control
    // (a start clear comes last so it wins, although the pipeline is always
    // empty whenever start is honoured).
    always_comb begin
        state_d     = state_q;
        accepted_d  = accepted_q;
        s1_vld_d    = fire_w;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_p_d      = s1_p_q;
        s1_idx_d    = s1_idx_q;
        s2_vld_d    = s1_vld_q;
        s2_fail_d   = s2_fail_q;
        s2_err_d    = s2_err_q;
        s2_idx_d    = s2_idx_q;
        pass_cnt_d  = pass_cnt_q;
        fail_cnt_d  = fail_cnt_q;
        err_sum_d   = err_sum_q;
        max_err_d   = max_err_q;
        ffail_idx_d = ffail_idx_q;
        ffail_vld_d = ffail_vld_q;

        if (fire_w) begin
            s1_a_d   = in_a;
            s1_b_d   = in_b;
            s1_p_d   = in_p;
            s1_idx_d = accepted_q;
        end

        if (s1_vld_q) begin
            s2_fail_d = (err_w != '0);
            s2_err_d  = err_w;
            s2_idx_d  = s1_idx_q;
        end

        if (s2_vld_q) begin
            if (s2_fail_q) begin
                fail_cnt_d = fail_cnt_q + CNT_W'(1);
                if (!ffail_vld_q) begin
                    ffail_idx_d = s2_idx_q;
                    ffail_vld_d = 1'b1;
                end
            end else begin
                pass_cnt_d = pass_cnt_q + CNT_W'(1);
            end
            err_sum_d = sum_ext_w[ERR_W] ? '1 : sum_ext_w[ERR_W-1:0];
            if (s2_err_q > max_err_q) begin
                max_err_d = s2_err_q;
            end
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_RUN;
                    accepted_d  = '0;
                    pass_cnt_d  = '0;
                    fail_cnt_d  = '0;
                    err_sum_d   = '0;
                    max_err_d   = '0;
                    ffail_idx_d = '0;
                    ffail_vld_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (fire_w) begin
                    accepted_d = accepted_q + CNT_W'(1);
                end
                if (accepted_d == CNT_W'(NUM_VECTORS)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!s1_vld_q && !s2_vld_q) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        done_d = (state_d == ST_DONE);
    end

    // State, pipeline and statistics registers; reset returns to an idle, empty checker.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            accepted_q  <= '0;
            done_q      <= 1'b0;
            s1_vld_q    <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_p_q      <= '0;
            s1_idx_q    <= '0;
            s2_vld_q    <= 1'b0;
            s2_fail_q   <= 1'b0;
            s2_err_q    <= '0;
            s2_idx_q    <= '0;
            pass_cnt_q  <= '0;
            fail_cnt_q  <= '0;
            err_sum_q   <= '0;
            max_err_q   <= '0;
            ffail_idx_q <= '0;
            ffail_vld_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            accepted_q  <= accepted_d;
            done_q      <= done_d;
            s1_vld_q    <= s1_vld_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_p_q      <= s1_p_d;
            s1_idx_q    <= s1_idx_d;
            s2_vld_q    <= s2_vld_d;
            s2_fail_q   <= s2_fail_d;
            s2_err_q    <= s2_err_d;
            s2_idx_q    <= s2_idx_d;
            pass_cnt_q  <= pass_cnt_d;
            fail_cnt_q  <= fail_cnt_d;
            err_sum_q   <= err_sum_d;
            max_err_q   <= max_err_d;
            ffail_idx_q <= ffail_idx_d;
            ffail_vld_q <= ffail_vld_d;
        end
    end

    assign in_ready       = ready_w;
    assign done           = done_q;
    assign pass_cnt       = pass_cnt_q;
    assign fail_cnt       = fail_cnt_q;
    assign err_sum        = err_sum_q;
    assign max_err        = max_err_q;
    assign first_fail_idx = ffail_idx_q;
    assign first_fail_vld = ffail_vld_q;

endmodule
